// File: rtl/babbage_pkg.sv
// Shared constants and state encoding for the difference-engine blocks (forward and inverse).
// Polynomial f(n) = 2n^2 + 3n + 5 is generated as f(0)=F0, g(0)=G1, constant second difference H.
// No logic here; consumers import it.
package babbage_pkg;

    localparam int F_W = 10;
    localparam int N_W = 4;

    localparam logic [F_W-1:0] F0    = 10'd5;
    localparam logic [F_W-1:0] G1    = 10'd5;
    localparam logic [F_W-1:0] H     = 10'd4;
    localparam logic [N_W-1:0] N_MAX = 4'd15;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t OP   = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/babbage_inv.sv
// Inverse difference engine: smallest n in 0..N_MAX with f(n) >= y, using adds only.
// Latency: done_tick 2+n cycles after start is accepted (2..17 with default parameters).
// Backpressure: none; start is only sampled in IDLE, requests in OP/DONE are dropped.
module babbage_inv
    import babbage_pkg::*;
#(
    parameter logic [F_W-1:0] F0    = babbage_pkg::F0,
    parameter logic [F_W-1:0] G1    = babbage_pkg::G1,
    parameter logic [F_W-1:0] H     = babbage_pkg::H,
    parameter logic [N_W-1:0] N_MAX = babbage_pkg::N_MAX
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [F_W-1:0] y,
    output logic           ready,
    output logic           done_tick,
    output logic [N_W-1:0] n,
    output logic           exact,
    output logic           found
);

    state_t         state;
    logic [F_W-1:0] f;
    logic [F_W-1:0] g;
    logic [N_W-1:0] idx;
    logic [F_W-1:0] y_lat;
    logic           done_q;

    logic f_ge_y;
    logic last_idx;

    assign f_ge_y    = (f >= y_lat);
    assign last_idx  = (idx == N_MAX);
    assign ready     = (state == IDLE);
    assign done_tick = done_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            f      <= '0;
            g      <= '0;
            idx    <= '0;
            y_lat  <= '0;
            n      <= '0;
            exact  <= 1'b0;
            found  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        y_lat <= y;
                        f     <= F0;
                        g     <= G1;
                        idx   <= '0;
                        state <= OP;
                    end
                end
                OP: begin
                    if (f_ge_y) begin
                        n      <= idx;
                        exact  <= (f == y_lat);
                        found  <= 1'b1;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (last_idx) begin
                        n      <= N_MAX;
                        exact  <= 1'b0;
                        found  <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        // One difference-engine step: f(i+1) = f(i) + g(i), g(i+1) = g(i) + H
                        f   <= f + g;
                        g   <= g + H;
                        idx <= idx + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_babbage_inv.sv
// Directed bench for babbage_inv: vector table, multi-cycle corner sequences, and a held-start sweep.
module tb_babbage_inv;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [9:0] y = 10'd0;
    logic       ready;
    logic       done_tick;
    logic [3:0] n;
    logic       exact;
    logic       found;

    int total = 0;
    int bad   = 0;

    babbage_inv dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .y         (y),
        .ready     (ready),
        .done_tick (done_tick),
        .n         (n),
        .exact     (exact),
        .found     (found)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] yv;
        int         en;
        int         ee;
        int         ef;
        int         lat;
    } vec_t;

    vec_t tab[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Closed-form reference: 2i^2 + 3i + 5
    function automatic int ref_f(input int i);
        return 2 * i * i + 3 * i + 5;
    endfunction

    function automatic int ref_n(input int yv);
        for (int i = 0; i <= 15; i++)
            if (ref_f(i) >= yv) return i;
        return 15;
    endfunction

    // Launch one search from IDLE; returns the cycle number (relative to accept edge) of done_tick.
    task automatic run_one(input logic [9:0] yv, output int lat, output int rdy_hi);
        @(negedge clk);
        y     = yv;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        lat    = 1;
        rdy_hi = 0;
        while (!done_tick && lat < 40) begin
            if (ready) rdy_hi++;
            @(negedge clk);
            lat++;
        end
        if (!done_tick) begin
            bad++;
            total++;
            $display("FAIL timeout: no done_tick for y=%0d within %0d cycles", yv, lat);
        end
    endtask

    initial begin
        int lat;
        int rdy_hi;
        int dones;
        int k;

        tab[0]  = '{10'd0,    0, 0, 1, 2};
        tab[1]  = '{10'd5,    0, 1, 1, 2};
        tab[2]  = '{10'd6,    1, 0, 1, 3};
        tab[3]  = '{10'd10,   1, 1, 1, 3};
        tab[4]  = '{10'd32,   3, 1, 1, 5};
        tab[5]  = '{10'd33,   4, 0, 1, 6};
        tab[6]  = '{10'd70,   5, 1, 1, 7};
        tab[7]  = '{10'd439, 14, 1, 1, 16};
        tab[8]  = '{10'd440, 15, 0, 1, 17};
        tab[9]  = '{10'd500, 15, 1, 1, 17};
        tab[10] = '{10'd501, 15, 0, 0, 17};
        tab[11] = '{10'd1023, 15, 0, 0, 17};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done_tick, 0);
        check("rst_n", n, 0);
        check("rst_exact", exact, 0);
        check("rst_found", found, 0);
        reset = 1'b1;

        // Start asserted while in reset must not launch a search
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        y     = 10'd100;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        check("rst_prio_ready", ready, 1);

        for (int i = 0; i < 12; i++) begin
            run_one(tab[i].yv, lat, rdy_hi);
            check($sformatf("vec%0d_lat", i), lat, tab[i].lat);
            check($sformatf("vec%0d_ready_busy", i), rdy_hi, 0);
            check($sformatf("vec%0d_n", i), n, tab[i].en);
            check($sformatf("vec%0d_exact", i), exact, tab[i].ee);
            check($sformatf("vec%0d_found", i), found, tab[i].ef);
            @(negedge clk);
            check($sformatf("vec%0d_pulse", i), done_tick, 0);
            check($sformatf("vec%0d_hold_n", i), n, tab[i].en);
            check($sformatf("vec%0d_idle_ready", i), ready, 1);
        end

        // Second start during OP is dropped
        @(negedge clk);
        y     = 10'd70;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        dones = 0;
        k     = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) begin
                y     = 10'd5;
                start = 1'b1;
            end
            if (c == 4) start = 1'b0;
            if (done_tick) begin
                dones++;
                k = c;
                check("ign_n", n, 5);
                check("ign_exact", exact, 1);
            end
            @(negedge clk);
        end
        check("ign_dones", dones, 1);
        check("ign_lat", k, 7);

        // Reset aborts a running search
        run_one(10'd32, lat, rdy_hi);
        check("pre_abort_n", n, 3);
        @(negedge clk);
        y     = 10'd500;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 6; c++) begin
            if (done_tick) dones++;
            if (c == 6) reset = 1'b0;
            @(negedge clk);
        end
        reset = 1'b1;
        check("abort_ready", ready, 1);
        check("abort_n", n, 0);
        check("abort_exact", exact, 0);
        check("abort_found", found, 0);
        for (int c = 0; c < 16; c++) begin
            if (done_tick) dones++;
            @(negedge clk);
        end
        check("abort_dones", dones, 0);
        run_one(10'd10, lat, rdy_hi);
        check("post_abort_lat", lat, 3);
        check("post_abort_n", n, 1);
        check("post_abort_exact", exact, 1);
        check("post_abort_found", found, 1);

        // Sweep with start held high: back-to-back searches
        @(negedge clk);
        @(negedge clk);
        y     = 10'd0;
        start = 1'b1;
        for (int v = 0; v <= 510; v++) begin
            lat    = 0;
            rdy_hi = 0;
            do begin
                @(negedge clk);
                lat++;
                if (ready) rdy_hi++;
            end while (!done_tick && lat < 40);
            if (!done_tick) begin
                bad++;
                total++;
                $display("FAIL sweep_timeout: y=%0d", v);
                start = 1'b0;
                break;
            end
            k = ref_n(v);
            check($sformatf("sweep%0d_n", v), n, k);
            check($sformatf("sweep%0d_exact", v), exact, (ref_f(k) == v) ? 1 : 0);
            check($sformatf("sweep%0d_found", v), found, (ref_f(k) >= v) ? 1 : 0);
            check($sformatf("sweep%0d_lat", v), lat, k + 2 + ((v > 0) ? 1 : 0));
            check($sformatf("sweep%0d_ready", v), rdy_hi, (v > 0) ? 1 : 0);
            if (v < 510) y = 10'(v + 1);
            else start = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("end_idle", ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
